mem_port_arbiter: RTL and testbench

- Shares one memory read/write port between C_RPORT cache read requesters and one write requester.
- Sits between the cache-side request interface and the memory/UART-side port. Fully synchronous, replacing edge-triggered sequencing with a single clocked FSM.
- Services one transaction at a time, with round-robin fairness among reads and read/write alternation.
- Includes a memory-ack timeout with a sticky error flag.

---
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory read/write port between C_RPORT cache readers and one writer.
// Round-robin among reads, alternation between read and write, ack timeout with sticky err.
module mem_port_arbiter #(
  parameter int C_RPORT = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int LEN_W   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [C_RPORT-1:0]        c_re,
  input  logic [C_RPORT*ADDR_W-1:0] c_raddr,
  input  logic [C_RPORT*LEN_W-1:0]  c_rlen,
  output logic [C_RPORT*DATA_W-1:0] c_dout,
  output logic [C_RPORT-1:0]        c_rack,
  input  logic                      c_we,
  input  logic [ADDR_W-1:0]         c_waddr,
  input  logic [LEN_W-1:0]          c_wlen,
  input  logic [DATA_W-1:0]         c_din,
  output logic                      c_wack,
  output logic                      m_re,
  output logic [ADDR_W-1:0]         m_raddr,
  output logic [LEN_W-1:0]          m_rlen,
  input  logic [DATA_W-1:0]         m_din,
  input  logic                      m_rack,
  output logic                      m_we,
  output logic [ADDR_W-1:0]         m_waddr,
  output logic [LEN_W-1:0]          m_wlen,
  output logic [DATA_W-1:0]         m_dout,
  input  logic                      m_wack,
  output logic                      busy,
  output logic                      err
);

  localparam int PW = (C_RPORT > 1) ? $clog2(C_RPORT) : 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, WR_WAIT, RD_ACK, WR_ACK
  } state_t;

  state_t        state, state_nx;
  logic [PW-1:0] g, rr_ptr, cand, rr_nx;
  logic [PW:0]   idx;
  logic          cand_vld, last_was_w;
  logic [TW-1:0] timer;
  logic          tmo_hit, tmo;
  logic          rd_go, wr_go, rd_fin, wr_fin, rd_rel, wr_rel;

  assign busy    = (state != IDLE);
  assign tmo_hit = (timer == TW'(TIMEOUT - 1));

  // first requesting port at or after rr_ptr, wrapping
  always_comb begin
    cand     = '0;
    cand_vld = 1'b0;
    idx      = '0;
    for (int i = 0; i < C_RPORT; i++) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(C_RPORT))
        idx = idx - (PW+1)'(C_RPORT);
      if (!cand_vld && c_re[idx[PW-1:0]]) begin
        cand_vld = 1'b1;
        cand     = idx[PW-1:0];
      end
    end
  end

  assign rr_nx = (cand == PW'(C_RPORT - 1)) ? '0 : cand + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rd_go    = 1'b0;
    wr_go    = 1'b0;
    rd_fin   = 1'b0;
    wr_fin   = 1'b0;
    rd_rel   = 1'b0;
    wr_rel   = 1'b0;
    tmo      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!m_rack && !m_wack) begin
          if (c_we && (!cand_vld || !last_was_w)) begin
            wr_go    = 1'b1;
            state_nx = WR_WAIT;
          end else if (cand_vld) begin
            rd_go    = 1'b1;
            state_nx = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (m_rack || tmo_hit) begin
          rd_fin   = 1'b1;
          tmo      = !m_rack;
          state_nx = RD_ACK;
        end
      end
      WR_WAIT: begin
        if (m_wack || tmo_hit) begin
          wr_fin   = 1'b1;
          tmo      = !m_wack;
          state_nx = WR_ACK;
        end
      end
      RD_ACK: begin
        if (!c_re[g]) begin
          rd_rel   = 1'b1;
          state_nx = IDLE;
        end
      end
      WR_ACK: begin
        if (!c_we) begin
          wr_rel   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g          <= '0;
      rr_ptr     <= '0;
      last_was_w <= 1'b0;
      timer      <= '0;
      m_re       <= 1'b0;
      m_raddr    <= '0;
      m_rlen     <= '0;
      m_we       <= 1'b0;
      m_waddr    <= '0;
      m_wlen     <= '0;
      m_dout     <= '0;
      c_dout     <= '0;
      c_rack     <= '0;
      c_wack     <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (state == RD_WAIT || state == WR_WAIT)
        timer <= timer + 1'b1;
      if (rd_go) begin
        g          <= cand;
        m_re       <= 1'b1;
        m_raddr    <= c_raddr[cand*ADDR_W +: ADDR_W];
        m_rlen     <= c_rlen[cand*LEN_W +: LEN_W];
        rr_ptr     <= rr_nx;
        last_was_w <= 1'b0;
        timer      <= '0;
      end
      if (wr_go) begin
        m_we       <= 1'b1;
        m_waddr    <= c_waddr;
        m_wlen     <= c_wlen;
        m_dout     <= c_din;
        last_was_w <= 1'b1;
        timer      <= '0;
      end
      // a timed-out read still acks, with zero data
      if (rd_fin) begin
        m_re                       <= 1'b0;
        c_rack[g]                  <= 1'b1;
        c_dout[g*DATA_W +: DATA_W] <= tmo ? '0 : m_din;
      end
      if (wr_fin) begin
        m_we   <= 1'b0;
        c_wack <= 1'b1;
      end
      if (tmo)    err    <= 1'b1;
      if (rd_rel) c_rack <= '0;
      if (wr_rel) c_wack <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a grant-order model.
// Includes a memory responder with configurable ack delay, hold and no-ack mode.
module tb_mem_port_arbiter;

  localparam int NP = 2;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    c_re = '0;
  logic [63:0]   c_raddr = '0;
  logic [3:0]    c_rlen = '0;
  logic [127:0]  c_dout;
  logic [1:0]    c_rack;
  logic          c_we = 1'b0;
  logic [31:0]   c_waddr = '0;
  logic [1:0]    c_wlen = '0;
  logic [63:0]   c_din = '0;
  logic          c_wack;
  logic          m_re;
  logic [31:0]   m_raddr;
  logic [1:0]    m_rlen;
  logic [63:0]   m_din = '0;
  logic          m_rack = 1'b0;
  logic          m_we;
  logic [31:0]   m_waddr;
  logic [1:0]    m_wlen;
  logic [63:0]   m_dout;
  logic          m_wack = 1'b0;
  logic          busy;
  logic          err;

  mem_port_arbiter #(
    .C_RPORT(NP), .ADDR_W(32), .DATA_W(64), .LEN_W(2), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .c_re(c_re), .c_raddr(c_raddr), .c_rlen(c_rlen),
    .c_dout(c_dout), .c_rack(c_rack),
    .c_we(c_we), .c_waddr(c_waddr), .c_wlen(c_wlen),
    .c_din(c_din), .c_wack(c_wack),
    .m_re(m_re), .m_raddr(m_raddr), .m_rlen(m_rlen),
    .m_din(m_din), .m_rack(m_rack),
    .m_we(m_we), .m_waddr(m_waddr), .m_wlen(m_wlen),
    .m_dout(m_dout), .m_wack(m_wack),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nbad = 0;

  int          dly = 1;
  int          hold = 0;
  bit          ack_en = 1'b1;
  bit          fix_en = 1'b0;
  logic [63:0] fix_data = '0;
  int          rcnt = 0, rleft = 0, wcnt = 0, wleft = 0;

  logic [31:0] raddr_v [NP];
  logic [1:0]  rlen_v [NP];
  logic [31:0] waddr_v;
  logic [1:0]  wlen_v;
  logic [63:0] wdata_v;
  logic [63:0] exp_dout [NP];
  int          exp_q [$];
  int          mrr = 0;
  bit          mlw = 1'b0;

  function automatic logic [63:0] memfn(input logic [31:0] a);
    return {~a, a};
  endfunction

  // memory side: ack after dly cycles of command, hold ack for hold extra cycles
  always @(negedge clk) begin
    if (rst) begin
      m_rack = 1'b0; m_wack = 1'b0;
      rcnt = 0; rleft = 0; wcnt = 0; wleft = 0;
    end else begin
      if (m_re && !m_rack) begin
        rcnt++;
        if (ack_en && rcnt >= dly) begin
          m_rack = 1'b1;
          m_din  = fix_en ? fix_data : memfn(m_raddr);
          rcnt   = 0;
          rleft  = hold;
        end
      end else if (!m_re) begin
        rcnt = 0;
        if (m_rack) begin
          if (rleft > 0) rleft--;
          else m_rack = 1'b0;
        end
      end
      if (m_we && !m_wack) begin
        wcnt++;
        if (ack_en && wcnt >= dly) begin
          m_wack = 1'b1;
          wcnt   = 0;
          wleft  = hold;
        end
      end else if (!m_we) begin
        wcnt = 0;
        if (m_wack) begin
          if (wleft > 0) wleft--;
          else m_wack = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_fields();
    c_raddr = {raddr_v[1], raddr_v[0]};
    c_rlen  = {rlen_v[1], rlen_v[0]};
    c_waddr = waddr_v;
    c_wlen  = wlen_v;
    c_din   = wdata_v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    mrr = 0;
    mlw = 1'b0;
    exp_dout[0] = '0;
    exp_dout[1] = '0;
  endtask

  // grant order from the arbitration rules for a set raised together
  function automatic void model_order(input bit [1:0] r, input bit w);
    int  p;
    bit  found;
    while (r != 2'b00 || w) begin
      found = 1'b0;
      p = 0;
      for (int i = 0; i < NP; i++) begin
        if (!found && r[(mrr + i) % NP]) begin
          found = 1'b1;
          p = (mrr + i) % NP;
        end
      end
      if (w && (!found || !mlw)) begin
        exp_q.push_back(2);
        mlw = 1'b1;
        w = 1'b0;
      end else begin
        exp_q.push_back(p);
        r[p] = 1'b0;
        mrr = (p + 1) % NP;
        mlw = 1'b0;
      end
    end
  endfunction

  // run requesters for r0/r1/rw transactions each, checking grants against exp_q
  task automatic run_round(input int r0, input int r1, input int rw);
    int rem [3];
    int k, obs, cyc;
    bit pre, pwe, pack;
    rem[0] = r0; rem[1] = r1; rem[2] = rw;
    k = 0;
    pre = m_re; pwe = m_we; pack = m_rack | m_wack;
    drive_fields();
    if (r0 > 0) c_re[0] = 1'b1;
    if (r1 > 0) c_re[1] = 1'b1;
    if (rw > 0) c_we = 1'b1;
    for (cyc = 0; cyc < 600; cyc++) begin
      step();
      if (m_re && !pre) begin
        obs = (m_raddr == raddr_v[1]) ? 1 : (m_raddr == raddr_v[0]) ? 0 : 7;
        chk("grant_seq", 64'(obs), 64'(k < exp_q.size() ? exp_q[k] : 9));
        if (obs < 2) chk("grant_rlen", 64'(m_rlen), 64'(rlen_v[obs]));
        chk("issue_ack_low", 64'(pack), 64'(0));
        k++;
      end
      if (m_we && !pwe) begin
        chk("grant_seq", 64'(2), 64'(k < exp_q.size() ? exp_q[k] : 9));
        chk("grant_waddr", 64'(m_waddr), 64'(waddr_v));
        chk("grant_wlen", 64'(m_wlen), 64'(wlen_v));
        chk("grant_wdata", m_dout, wdata_v);
        chk("issue_ack_low", 64'(pack), 64'(0));
        k++;
      end
      for (int p = 0; p < NP; p++) begin
        if (c_re[p] && c_rack[p]) begin
          exp_dout[p] = memfn(raddr_v[p]);
          chk("read_data", c_dout[p*64 +: 64], exp_dout[p]);
          c_re[p] = 1'b0;
          rem[p]--;
        end else if (!c_re[p] && !c_rack[p] && rem[p] > 0) begin
          c_re[p] = 1'b1;
        end
      end
      if (c_we && c_wack) begin
        c_we = 1'b0;
        rem[2]--;
      end else if (!c_we && !c_wack && rem[2] > 0) begin
        c_we = 1'b1;
      end
      pre = m_re; pwe = m_we; pack = m_rack | m_wack;
      if (rem[0] == 0 && rem[1] == 0 && rem[2] == 0 && !busy &&
          c_rack == 2'b00 && !c_wack && c_re == 2'b00 && !c_we)
        break;
    end
    chk("round_in_budget", 64'(cyc < 600), 64'(1));
    chk("grant_count", 64'(k), 64'(exp_q.size()));
    chk("dout0_kept", c_dout[63:0], exp_dout[0]);
    chk("dout1_kept", c_dout[127:64], exp_dout[1]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int subset;
    raddr_v[0] = '0; raddr_v[1] = '0;
    rlen_v[0] = '0; rlen_v[1] = '0;
    waddr_v = '0; wlen_v = '0; wdata_v = '0;
    exp_dout[0] = '0; exp_dout[1] = '0;

    #2 rst = 1'b1;
    step();
    step();
    chk("rst_m_re", 64'(m_re), 64'(0));
    chk("rst_m_we", 64'(m_we), 64'(0));
    chk("rst_c_rack", 64'(c_rack), 64'(0));
    chk("rst_c_wack", 64'(c_wack), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_dout0", c_dout[63:0], 64'(0));
    chk("rst_dout1", c_dout[127:64], 64'(0));
    chk("rst_m_raddr", 64'(m_raddr), 64'(0));
    chk("rst_m_dout", m_dout, 64'(0));
    rst = 1'b0;

    // single read on port 0, memory acks after 3 cycles
    raddr_v[0] = 32'h100;
    rlen_v[0]  = 2'd3;
    drive_fields();
    fix_en = 1'b1;
    fix_data = 64'hDEAD_BEEF;
    dly = 3;
    c_re[0] = 1'b1;
    n = 0;
    while (!m_re && n < 20) begin step(); n++; end
    chk("t1_m_re", 64'(m_re), 64'(1));
    chk("t1_issue_lat", 64'(n), 64'(1));
    chk("t1_m_raddr", 64'(m_raddr), 64'h100);
    chk("t1_m_rlen", 64'(m_rlen), 64'(3));
    chk("t1_busy", 64'(busy), 64'(1));
    n = 0;
    while (!c_rack[0] && n < 20) begin step(); n++; end
    chk("t1_ack_lat", 64'(n), 64'(3));
    chk("t1_dout0", c_dout[63:0], 64'hDEAD_BEEF);
    chk("t1_m_re_low", 64'(m_re), 64'(0));
    step();
    step();
    chk("t1_rack_held", 64'(c_rack[0]), 64'(1));
    c_re[0] = 1'b0;
    step();
    chk("t1_rack_fall", 64'(c_rack[0]), 64'(0));
    chk("t1_busy_low", 64'(busy), 64'(0));
    chk("t1_dout1_kept", c_dout[127:64], 64'(0));
    fix_en = 1'b0;

    // round-robin between two persistent readers
    do_reset();
    dly = 1;
    raddr_v[0] = 32'h0000_2000;
    raddr_v[1] = 32'h0000_3001;
    rlen_v[0] = 2'd1;
    rlen_v[1] = 2'd2;
    exp_q.delete();
    exp_q.push_back(0); exp_q.push_back(1);
    exp_q.push_back(0); exp_q.push_back(1);
    run_round(2, 2, 0);

    // read/write alternation, write first after reset
    waddr_v = 32'h0000_4440;
    wlen_v  = 2'd3;
    wdata_v = 64'h0123_4567_89AB_CDEF;
    dly = 2;
    exp_q.delete();
    exp_q.push_back(2); exp_q.push_back(0);
    exp_q.push_back(2); exp_q.push_back(0);
    run_round(2, 0, 2);

    // timeout on port 1: memory never answers
    ack_en = 1'b0;
    raddr_v[1] = 32'h0000_5551;
    drive_fields();
    c_re[1] = 1'b1;
    n = 0;
    while (!m_re && n < 20) begin step(); n++; end
    chk("t4_m_raddr", 64'(m_raddr), 64'h5551);
    n = 0;
    while (m_re && n < 50) begin step(); n++; end
    chk("t4_m_re_cycles", 64'(n), 64'(TMO));
    chk("t4_err", 64'(err), 64'(1));
    chk("t4_rack1", 64'(c_rack[1]), 64'(1));
    chk("t4_dout1_zero", c_dout[127:64], 64'(0));
    c_re[1] = 1'b0;
    step();
    chk("t4_rack1_fall", 64'(c_rack[1]), 64'(0));
    chk("t4_busy_low", 64'(busy), 64'(0));
    exp_dout[1] = '0;
    mrr = 0;
    mlw = 1'b0;
    ack_en = 1'b1;
    step();
    step();
    chk("t4_err_sticky", 64'(err), 64'(1));

    // reset in the middle of a read
    dly = 6;
    raddr_v[0] = 32'h0000_6660;
    drive_fields();
    c_re[0] = 1'b1;
    n = 0;
    while (!m_re && n < 20) begin step(); n++; end
    step();
    step();
    chk("t5_in_wait", 64'(m_re), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("t5_m_re_drop", 64'(m_re), 64'(0));
    chk("t5_rack", 64'(c_rack), 64'(0));
    chk("t5_wack", 64'(c_wack), 64'(0));
    chk("t5_busy", 64'(busy), 64'(0));
    chk("t5_err_clr", 64'(err), 64'(0));
    c_re = 2'b00;
    do_reset();
    dly = 2;
    exp_q.delete();
    exp_q.push_back(0);
    run_round(1, 0, 0);
    chk("t5_err_stays_clr", 64'(err), 64'(0));

    // memory keeps its ack high 2 extra cycles; next issue must wait
    hold = 2;
    dly = 1;
    raddr_v[0] = 32'h0000_7770;
    raddr_v[1] = 32'h0000_8881;
    exp_q.delete();
    exp_q.push_back(1); exp_q.push_back(0);
    run_round(1, 1, 0);
    mrr = 1;
    mlw = 1'b0;

    // randomized rounds checked against the grant-order model
    do_reset();
    for (int r = 0; r < 40; r++) begin
      subset = int'($urandom_range(1, 7));
      for (int p = 0; p < NP; p++) begin
        raddr_v[p] = ($urandom & 32'hFFFF_FFF0) | 32'(p);
        rlen_v[p]  = 2'($urandom);
      end
      waddr_v = $urandom;
      wlen_v  = 2'($urandom);
      wdata_v = {$urandom, $urandom};
      dly  = int'($urandom_range(1, 4));
      hold = int'($urandom_range(0, 1));
      exp_q.delete();
      model_order(subset[1:0], subset[2]);
      run_round(subset[0] ? 1 : 0, subset[1] ? 1 : 0, subset[2] ? 1 : 0);
    end
    chk("rand_err_clear", 64'(err), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
